// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access scheduler: state encoding, time-word
// field layout, default initial time and BCD validation helpers.
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHK_RD  = 3'd1,
    S_INIT_WR = 3'd2,
    S_POLL_RD = 3'd3,
    S_SET_WR  = 3'd4
  } state_t;

  // Field offsets within the packed {year, week, month, date, hour, minute, second} word.
  localparam int SEC_LSB   = 0;
  localparam int MIN_LSB   = 8;
  localparam int HOUR_LSB  = 16;
  localparam int DATE_LSB  = 24;
  localparam int MONTH_LSB = 32;
  localparam int WEEK_LSB  = 40;
  localparam int YEAR_LSB  = 48;
  localparam int CH_BIT    = SEC_LSB + 7;

  localparam logic [55:0] DEFAULT_INIT_TIME = 56'h16_02_12_13_13_10_01;

  function automatic logic bcd_nibble_ok(input logic [3:0] n);
    return n <= 4'd9;
  endfunction

  function automatic logic time_word_ok(input logic [55:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (!bcd_nibble_ok(t[i*4 +: 4])) ok = 1'b0;
    end
    if (t[CH_BIT]) ok = 1'b0;
    if (t[MONTH_LSB +: 8] == 8'h00) ok = 1'b0;
    if (t[DATE_LSB +: 8] == 8'h00) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Free-running poll interval counter with a sticky "poll due" flag that stays
// set until the scheduler services it.
module rtc_poll_timer #(
  parameter int POLL_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic poll_due
);

  localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = (count == CW'(POLL_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      poll_due <= 1'b0;
    end else begin
      count <= wrap ? '0 : count + CW'(1);
      // A fresh expiry beats a same-cycle clear so no period is lost.
      if (wrap)       poll_due <= 1'b1;
      else if (clear) poll_due <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_access_sched.sv
// Arbitrates the ds1302 driver's read/write handshakes between the start-up
// clock-halt check, periodic polling and user set-time requests.
module rtc_access_sched
  import rtc_pkg::*;
#(
  parameter int          POLL_CYCLES = 12_500_000,
  parameter logic [55:0] INIT_TIME   = DEFAULT_INIT_TIME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_req,
  input  logic [55:0] set_time,
  output logic        set_ack,
  output logic        set_err,
  output logic [55:0] time_now,
  output logic        time_valid,
  output logic        busy,
  output logic        write_time_req,
  input  logic        write_time_ack,
  output logic [55:0] write_time,
  output logic        read_time_req,
  input  logic        read_time_ack,
  input  logic [55:0] read_time
);

  state_t      state;
  logic        chk_done;
  logic        set_pending;
  logic [55:0] set_word;
  logic        poll_due;
  logic        poll_clear;
  logic        set_valid;
  logic        set_now;
  logic [55:0] set_next;

  // A valid request this cycle counts as pending already, so it beats a due poll.
  assign set_valid  = set_req && time_word_ok(set_time);
  assign set_now    = set_pending || set_valid;
  assign set_next   = set_valid ? set_time : set_word;
  assign poll_clear = (state == S_POLL_RD) && read_time_req && read_time_ack;
  assign busy       = (state != S_IDLE);

  rtc_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (poll_clear),
    .poll_due (poll_due)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      chk_done       <= 1'b0;
      set_pending    <= 1'b0;
      set_word       <= '0;
      set_ack        <= 1'b0;
      set_err        <= 1'b0;
      time_now       <= '0;
      time_valid     <= 1'b0;
      write_time_req <= 1'b0;
      write_time     <= '0;
      read_time_req  <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      set_ack    <= 1'b0;
      set_err    <= set_req && !set_valid;

      if (set_valid) begin
        set_word    <= set_time;
        set_pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!chk_done) begin
            chk_done <= 1'b1;
            state    <= S_CHK_RD;
          end else if (set_now) begin
            set_pending <= 1'b0;
            write_time  <= set_next;
            state       <= S_SET_WR;
          end else if (poll_due) begin
            state <= S_POLL_RD;
          end
        end

        S_CHK_RD, S_POLL_RD: begin
          // Acks are honoured only while our own request is up.
          if (!read_time_req) begin
            read_time_req <= 1'b1;
          end else if (read_time_ack) begin
            read_time_req <= 1'b0;
            if (state == S_CHK_RD && read_time[CH_BIT]) begin
              write_time <= INIT_TIME;
              state      <= S_INIT_WR;
            end else begin
              time_now   <= read_time;
              time_valid <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end

        S_INIT_WR, S_SET_WR: begin
          if (!write_time_req) begin
            write_time_req <= 1'b1;
          end else if (write_time_ack) begin
            write_time_req <= 1'b0;
            set_ack        <= (state == S_SET_WR);
            state          <= S_POLL_RD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_sched.sv
// Directed bench for rtc_access_sched with a behavioural ds1302 driver model.
module tb_rtc_access_sched;

  localparam int          POLL     = 100;
  localparam int          LAT      = 3;
  localparam logic [55:0] INIT_VAL = 56'h16_02_12_13_13_10_01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_req = 1'b0;
  logic [55:0] set_time = '0;
  logic        set_ack, set_err, time_valid, busy;
  logic [55:0] time_now, write_time;
  logic        write_time_req, read_time_req;
  logic        write_time_ack = 1'b0;
  logic        read_time_ack = 1'b0;
  logic [55:0] read_time = '0;

  always #5 clk = ~clk;

  rtc_access_sched #(.POLL_CYCLES(POLL), .INIT_TIME(INIT_VAL)) dut (
    .clk            (clk),
    .rst            (rst),
    .set_req        (set_req),
    .set_time       (set_time),
    .set_ack        (set_ack),
    .set_err        (set_err),
    .time_now       (time_now),
    .time_valid     (time_valid),
    .busy           (busy),
    .write_time_req (write_time_req),
    .write_time_ack (write_time_ack),
    .write_time     (write_time),
    .read_time_req  (read_time_req),
    .read_time_ack  (read_time_ack),
    .read_time      (read_time)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [55:0] got, input logic [55:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver model state and event counters
  logic [55:0] rtc_reg = '0;
  logic [55:0] last_read = '0;
  logic [55:0] last_write = '0;
  int n_reads = 0, n_writes = 0, n_valid = 0, n_set_ack = 0, n_set_err = 0;
  int overlap = 0, rd_cnt = 0, wr_cnt = 0, cyc = 0, last_ack_cyc = 0, reads_at_write = 0;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    read_time_ack  = 1'b0;
    write_time_ack = 1'b0;
    if (time_valid) n_valid++;
    if (set_ack) n_set_ack++;
    if (set_err) n_set_err++;
    if (read_time_req && write_time_req) overlap++;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (read_time_req) begin
        if (rd_cnt == LAT) begin
          read_time     = rtc_reg;
          read_time_ack = 1'b1;
          last_read     = rtc_reg;
          rtc_reg       = rtc_reg + 56'd1;
          n_reads++;
          last_ack_cyc  = cyc;
          rd_cnt        = 0;
        end else rd_cnt++;
      end
      if (write_time_req) begin
        if (wr_cnt == LAT) begin
          write_time_ack = 1'b1;
          rtc_reg        = write_time;
          last_write     = write_time;
          n_writes++;
          reads_at_write = n_reads;
          wr_cnt         = 0;
        end else wr_cnt++;
      end
    end
  end

  task automatic clear_counts();
    n_reads = 0; n_writes = 0; n_valid = 0; n_set_ack = 0; n_set_err = 0;
  endtask

  task automatic do_reset(input logic [55:0] rtc_init);
    @(negedge clk);
    rst = 1'b1;
    set_req = 1'b0;
    repeat (3) @(negedge clk);
    rtc_reg = rtc_init;
    clear_counts();
    rst = 1'b0;
  endtask

  task automatic wait_reads(input int target, input int budget);
    int n;
    n = 0;
    while (n_reads < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_reads_in_time", 56'(n_reads >= target), 56'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("wait_idle_in_time", 56'(busy), 56'd0);
  endtask

  task automatic wait_set_acks(input int target, input int budget);
    int n;
    n = 0;
    while (n_set_ack < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_set_ack_in_time", 56'(n_set_ack >= target), 56'd1);
  endtask

  task automatic wait_poll_req(input int budget);
    int n;
    n = 0;
    while (!read_time_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_poll_req", 56'(read_time_req), 56'd1);
  endtask

  task automatic pulse_set(input logic [55:0] w);
    set_time = w;
    set_req  = 1'b1;
    @(negedge clk);
    set_req  = 1'b0;
  endtask

  initial begin
    int t_prev, rb, wb, ab, eb, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_time_now", time_now, 56'd0);
    check("rst_write_time", write_time, 56'd0);
    check("rst_flags", 56'({time_valid, set_ack, set_err, busy, read_time_req, write_time_req}), 56'd0);

    // Start-up with CH = 1: init write, then readback
    rtc_reg = 56'h00_00_00_00_00_00_80;
    clear_counts();
    rst = 1'b0;
    @(negedge clk);
    check("a_busy_entry", 56'(busy), 56'd1);
    check("a_rdreq_entry", 56'(read_time_req), 56'd0);
    @(negedge clk);
    check("a_rdreq_rise", 56'(read_time_req), 56'd1);
    wait_reads(2, 200);
    wait_idle(20);
    check("a_writes", 56'(n_writes), 56'd1);
    check("a_init_word", last_write, INIT_VAL);
    check("a_time_now", time_now, INIT_VAL);
    check("a_valid_cnt", 56'(n_valid), 56'd1);

    // Start-up with CH = 0: value taken as-is, no write
    do_reset(56'h24_03_15_05_23_59_59);
    n = 0;
    while (!read_time_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_ack_seen", 56'(read_time_ack), 56'd1);
    @(negedge clk);
    check("b_valid_pulse", 56'(time_valid), 56'd1);
    check("b_time_now", time_now, 56'h24_03_15_05_23_59_59);
    wait_idle(20);
    check("b_writes", 56'(n_writes), 56'd0);
    check("b_valid_cnt", 56'(n_valid), 56'd1);

    // Polling: fixed interval between poll reads, one valid per read
    wait_reads(2, 250);
    t_prev = last_ack_cyc;
    for (int i = 1; i <= 9; i++) begin
      wait_reads(2 + i, 250);
      check("c_interval", 56'(last_ack_cyc - t_prev), 56'(POLL));
      t_prev = last_ack_cyc;
    end
    wait_idle(20);
    check("c_valid_eq_reads", 56'(n_valid), 56'(n_reads));
    check("c_time_now", time_now, last_read);

    // User set during a poll read
    wait_poll_req(250);
    @(negedge clk);
    rb = n_reads; wb = n_writes; ab = n_set_ack;
    pulse_set(56'h25_01_01_01_00_00_00);
    wait_set_acks(ab + 1, 100);
    wait_reads(rb + 2, 100);
    wait_idle(20);
    check("d_writes", 56'(n_writes), 56'(wb + 1));
    check("d_write_word", last_write, 56'h25_01_01_01_00_00_00);
    check("d_read_before_write", 56'(reads_at_write), 56'(rb + 1));
    check("d_set_ack_cnt", 56'(n_set_ack), 56'(ab + 1));
    check("d_time_now", time_now, 56'h25_01_01_01_00_00_00);

    // Invalid sets
    wb = n_writes; eb = n_set_err;
    pulse_set(56'h25_01_01_01_00_7A_00);
    check("e_err_minute", 56'(set_err), 56'd1);
    @(negedge clk);
    check("e_err_one_cycle", 56'(set_err), 56'd0);
    pulse_set(56'h25_01_00_01_00_00_00);
    check("e_err_month", 56'(set_err), 56'd1);
    @(negedge clk);
    pulse_set(56'h25_01_01_01_00_00_80);
    check("e_err_second", 56'(set_err), 56'd1);
    repeat (20) @(negedge clk);
    check("e_no_write", 56'(n_writes), 56'(wb));
    check("e_err_cnt", 56'(n_set_err), 56'(eb + 3));

    // Two valid sets while pending: last wins, one ack
    wait_poll_req(250);
    @(negedge clk);
    wb = n_writes; ab = n_set_ack;
    pulse_set(56'h25_02_02_02_10_20_30);
    pulse_set(56'h25_03_03_03_11_22_33);
    wait_set_acks(ab + 1, 100);
    wait_idle(50);
    check("e_last_wins_now", time_now, 56'h25_03_03_03_11_22_33);
    repeat (10) @(negedge clk);
    check("e_last_wins_word", last_write, 56'h25_03_03_03_11_22_33);
    check("e_one_write", 56'(n_writes), 56'(wb + 1));
    check("e_one_ack", 56'(n_set_ack), 56'(ab + 1));

    // Reset during a user write
    wait_idle(50);
    pulse_set(56'h25_04_04_04_12_34_56);
    n = 0;
    while (!write_time_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("f_wr_req_up", 56'(write_time_req), 56'd1);
    ab = n_set_ack; wb = n_writes;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("f_reqs_drop", 56'({read_time_req, write_time_req, busy}), 56'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("f_chk_entry_busy", 56'(busy), 56'd1);
    @(negedge clk);
    check("f_chk_rdreq", 56'(read_time_req), 56'd1);
    wait_idle(50);
    check("f_no_set_ack", 56'(n_set_ack), 56'(ab));
    check("f_no_write", 56'(n_writes), 56'(wb));

    check("no_req_overlap", 56'(overlap), 56'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
